// File: rtl/demux1to2_32.sv
// rtl/demux1to2_32.sv - registered 1-to-2 valid/ready stream demux, one holding slot per output
// Optional strict global ordering across both outputs: define DEMUX1TO2_32_ORDER_EN.
module demux1to2_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t a_state;
    slot_state_t b_state;

    logic a_free;
    logic b_free;
    logic xfer;
    logic a_load;
    logic b_load;

    // A slot can take a word if it is empty or its current word leaves this cycle.
    assign a_free = (a_state == EMPTY) | a_ready;
    assign b_free = (b_state == EMPTY) | b_ready;

`ifdef DEMUX1TO2_32_ORDER_EN
    // The other slot must also be empty or draining, so words leave in source order.
    assign in_ready = in_sel ? (a_free & ((b_state == EMPTY) | b_ready))
                             : (b_free & ((a_state == EMPTY) | a_ready));
`else
    assign in_ready = in_sel ? a_free : b_free;
`endif

    assign xfer   = in_valid & in_ready;
    assign a_load = xfer & in_sel;
    assign b_load = xfer & ~in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
            a_data  <= '0;
            b_data  <= '0;
        end else begin
            case (a_state)
                EMPTY: begin
                    if (a_load) begin
                        a_state <= FULL;
                        a_data  <= in_data;
                    end
                end
                FULL: begin
                    if (a_load) begin
                        a_data <= in_data;
                    end else if (a_ready) begin
                        a_state <= EMPTY;
                    end
                end
                default: a_state <= EMPTY;
            endcase

            case (b_state)
                EMPTY: begin
                    if (b_load) begin
                        b_state <= FULL;
                        b_data  <= in_data;
                    end
                end
                FULL: begin
                    if (b_load) begin
                        b_data <= in_data;
                    end else if (b_ready) begin
                        b_state <= EMPTY;
                    end
                end
                default: b_state <= EMPTY;
            endcase
        end
    end

    assign a_valid = (a_state == FULL);
    assign b_valid = (b_state == FULL);

endmodule
